// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, control and instruction-memory write signals of the loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10
) ();

    logic                  start;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  proc_run;
    logic                  done;
    logic                  error;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata, word_count, proc_run, done, error
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata, word_count, proc_run, done, error
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Shifts stream bytes into a big-endian 32-bit word; word_valid_o is a registered one-cycle strobe.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [1:0]  idx_q;
    logic [31:0] shift_q;
    logic        valid_q;

    assign last_byte_o  = shift_i && (idx_q == LAST_IDX);
    assign word_valid_o = valid_q;
    assign word_o       = shift_q;

    // Partial-word state is only touched by an accepted byte, so stream stalls keep it intact.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            idx_q   <= 2'd0;
            shift_q <= 32'd0;
            valid_q <= 1'b0;
        end else if (shift_i) begin
            shift_q <= {shift_q[23:0], byte_i};
            idx_q   <= idx_q + 2'd1;
            valid_q <= (idx_q == LAST_IDX);
        end else begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: length-prefixed byte stream -> sequential imem word writes, gates proc_run.
// Define IMEM_LOADER_CHECKSUM_EN to require and check a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    imem_loader_if.slave    bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e AFTER_PAYLOAD = ST_CSUM;
`else
    localparam state_e AFTER_PAYLOAD = ST_DONE;
`endif
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_e                   state_q, state_d;
    logic                     byteReady_q, done_q, error_q, procRun_q;
    logic [8*LEN_BYTES-1:0]   len_q;
    logic [ADDR_WIDTH:0]      wordCount_q;
    logic [ADDR_WIDTH-1:0]    imemAddr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]               csum_q;
`endif

    logic                     xfer_d, startLoad_d, lastByte_d, wordDone_d, lastWord_d, tooLong_d;
    logic [8*LEN_BYTES-1:0]   lenFull_d;
    logic                     packValid_d;
    logic [31:0]              packWord_d;

    assign xfer_d      = bus.byte_valid && byteReady_q;
    assign startLoad_d = bus.start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign lenFull_d   = {len_q[15:8], bus.byte_in};
    assign tooLong_d   = {1'b0, lenFull_d} > MAX_WORDS;
    assign wordDone_d  = lastByte_d;
    assign lastWord_d  = (17'(wordCount_q) + 17'd1) == {1'b0, len_q};

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (state_q != ST_DATA),
        .shift_i      (xfer_d && (state_q == ST_DATA)),
        .byte_i       (bus.byte_in),
        .last_byte_o  (lastByte_d),
        .word_valid_o (packValid_d),
        .word_o       (packWord_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (bus.start) state_d = ST_LEN_HI;
            ST_LEN_HI: if (xfer_d) state_d = ST_LEN_LO;
            ST_LEN_LO: begin
                if (xfer_d) begin
                    if (tooLong_d)              state_d = ST_ERROR;
                    else if (lenFull_d == '0)   state_d = AFTER_PAYLOAD;
                    else                        state_d = ST_DATA;
                end
            end
            ST_DATA: if (wordDone_d && lastWord_d) state_d = AFTER_PAYLOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: if (xfer_d) state_d = (bus.byte_in == csum_q) ? ST_DONE : ST_ERROR;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered decodes of the next state, so they line up with imem_we.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byteReady_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            procRun_q   <= 1'b0;
            len_q       <= '0;
            wordCount_q <= '0;
            imemAddr_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            byteReady_q <= state_d inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM};
            done_q      <= (state_d == ST_DONE);
            procRun_q   <= (state_d == ST_DONE);
            error_q     <= (state_d == ST_ERROR);

            if (xfer_d && state_q == ST_LEN_HI) len_q[15:8] <= bus.byte_in;
            if (xfer_d && state_q == ST_LEN_LO) len_q[7:0]  <= bus.byte_in;

            if (startLoad_d) begin
                wordCount_q <= '0;
            end else if (wordDone_d) begin
                imemAddr_q  <= wordCount_q[ADDR_WIDTH-1:0];
                wordCount_q <= wordCount_q + 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (startLoad_d)
                csum_q <= 8'd0;
            else if (xfer_d && state_q == ST_DATA)
                csum_q <= csum_q ^ bus.byte_in;
`endif
        end
    end

    assign bus.byte_ready = byteReady_q;
    assign bus.imem_we    = packValid_d;
    assign bus.imem_addr  = imemAddr_q;
    assign bus.imem_wdata = packWord_d;
    assign bus.word_count = wordCount_q;
    assign bus.proc_run   = procRun_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (ADDR_WIDTH = 4); honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [AW:0]   count;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;
    wr_t  expQ[$];
    wr_t  monE;
    logic [31:0] words[$];
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] lastCsum;
`endif

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected write: addr 0x%0h data 0x%0h, expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                monE = expQ.pop_front();
                check("write addr",  32'(bus.imem_addr),  32'(monE.addr));
                check("write data",  bus.imem_wdata,      monE.data);
                check("write count", 32'(bus.word_count), 32'(monE.count));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit accepted = 1'b0;
        int guard    = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!accepted && guard < 100) begin
            @(negedge clk);
            accepted = bus.byte_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.byte_valid = 1'b0;
        if (!accepted) begin
            checks++;
            fails++;
            $display("[TB] FAIL byte accept: byte 0x%0h not accepted, expected byte_ready", b);
        end
    endtask

    // Start a load of n words from 'words'; optionally stall randomly or stop after abortAfter payload bytes.
    task automatic applyStimulus(input int n, input bit stall, input int abortAfter);
        logic [15:0] len = 16'(n);
        logic [7:0]  b;
        logic [7:0]  cs  = 8'd0;
        wr_t         e;
        int          sent = 0;
        pulseStart();
        sendByte(len[15:8]);
        if (stall) idle(2);
        sendByte(len[7:0]);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (abortAfter >= 0 && sent == abortAfter) return;
                b  = words[i][31-8*k -: 8];
                cs = cs ^ b;
                if (stall) begin
                    idle(int'($urandom_range(0, 2)));
                    if (i == 0 && k == 2) pulseStart();
                end
                if (k == 3) begin
                    e.addr  = AW'(i);
                    e.data  = words[i];
                    e.count = (AW+1)'(i + 1);
                    expQ.push_back(e);
                end
                sendByte(b);
                sent++;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        lastCsum = cs;
`endif
    endtask

    task automatic checkOutput(input string tag, input logic expDone, input logic expErr,
                               input logic expRun, input int expCount, input logic expReady);
        check({tag, " done"},       32'(bus.done),       32'(expDone));
        check({tag, " error"},      32'(bus.error),      32'(expErr));
        check({tag, " proc_run"},   32'(bus.proc_run),   32'(expRun));
        check({tag, " word_count"}, 32'(bus.word_count), 32'(expCount));
        check({tag, " byte_ready"}, 32'(bus.byte_ready), 32'(expReady));
    endtask

    task automatic checkReset(input string tag);
        checkOutput(tag, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check({tag, " imem_we"},    32'(bus.imem_we),   32'd0);
        check({tag, " imem_addr"},  32'(bus.imem_addr), 32'd0);
        check({tag, " imem_wdata"}, bus.imem_wdata,     32'd0);
    endtask

    task automatic setNominal();
        words = {32'h2008_0005, 32'h8C09_0004};
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;
        rst_n          = 1'b0;
        idle(2);
        rst_n = 1'b1;
        checkReset("reset");

        $display("[TB] nominal two-word load");
        setNominal();
        applyStimulus(2, 1'b0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(lastCsum);
`endif
        checkOutput("nominal", 1'b1, 1'b0, 1'b1, 2, 1'b0);
        idle(1);
        check("nominal we width", 32'(bus.imem_we), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] bad checksum");
        applyStimulus(2, 1'b0, -1);
        sendByte(lastCsum ^ 8'h01);
        checkOutput("bad csum", 1'b0, 1'b1, 1'b0, 2, 1'b0);
`endif

        $display("[TB] oversize length");
        pulseStart();
        check("restart ready", 32'(bus.byte_ready), 32'd1);
        check("restart clears done", 32'(bus.done), 32'd0);
        sendByte(8'h00);
        sendByte(8'h11);
        checkOutput("oversize", 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(3);
        check("oversize stays ready low", 32'(bus.byte_ready), 32'd0);

        $display("[TB] full-capacity load");
        words = {};
        for (int i = 0; i < 16; i++) words.push_back(32'hA500_0000 ^ (32'(i) * 32'h0101_0101));
        pulseStart();
        check("restart clears error", 32'(bus.error), 32'd0);
        idle(1);
        applyStimulus(16, 1'b0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(lastCsum);
`endif
        checkOutput("capacity", 1'b1, 1'b0, 1'b1, 16, 1'b0);

        $display("[TB] zero length");
        applyStimulus(0, 1'b0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(8'h00);
`endif
        checkOutput("zero", 1'b1, 1'b0, 1'b1, 0, 1'b0);

        $display("[TB] stalled stream with stray start");
        setNominal();
        applyStimulus(2, 1'b1, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(lastCsum);
`endif
        checkOutput("stalled", 1'b1, 1'b0, 1'b1, 2, 1'b0);

        $display("[TB] reset during payload");
        applyStimulus(2, 1'b0, 6);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        checkReset("mid reset");
        idle(2);
        checkReset("after reset idle");
        applyStimulus(2, 1'b0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(lastCsum);
`endif
        checkOutput("reload", 1'b1, 1'b0, 1'b1, 2, 1'b0);

        idle(3);
        check("pending writes", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
